// File: rtl/fft_pkg.sv
// Shared FFT pipeline types and constants: word widths, stage-phase codes,
// and the complex sample bundle.
package fft_pkg;

  localparam int DW      = 24;
  localparam int TW_FRAC = 8;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BFLY = 2'd1;
  localparam logic [1:0] ST_TWID = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd3;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cmul_q.sv
// Combinational complex multiply by a Q(FRAC) twiddle with arithmetic shift;
// SDF_ROUND_EN adds a half-LSB before the shift (round-half-up).
module cmul_q #(
  parameter int DW   = fft_pkg::DW,
  parameter int FRAC = fft_pkg::TW_FRAC
) (
  input  logic signed [DW-1:0] a_r,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] w_r,
  input  logic signed [DW-1:0] w_i,
  output logic signed [DW-1:0] p_r,
  output logic signed [DW-1:0] p_i
);

  localparam int PW = 2*DW + 1;

  logic signed [2*DW-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0]   sr, si;
  logic                   unused_bits;

  always_comb begin
    rr = a_r * w_r;
    ii = a_i * w_i;
    ri = a_r * w_i;
    ir = a_i * w_r;
    sr = PW'(rr) - PW'(ii);
    si = PW'(ri) + PW'(ir);
`ifdef SDF_ROUND_EN
    sr = sr + (PW'(1) << (FRAC-1));
    si = si + (PW'(1) << (FRAC-1));
`endif
  end

  // floor shift then truncate == take DW bits starting at FRAC
  assign p_r = sr[FRAC +: DW];
  assign p_i = si[FRAC +: DW];

  assign unused_bits = ^{sr[FRAC-1:0], sr[PW-1:FRAC+DW],
                         si[FRAC-1:0], si[PW-1:FRAC+DW]};

endmodule

// File: rtl/sdf_bfly_stage_8.sv
// Radix-2 SDF butterfly stage with 8-deep feedback delay line.
// Build option SDF_ROUND_EN: round-half-up in the twiddle multiply.
module sdf_bfly_stage_8 #(
  parameter int DW      = fft_pkg::DW,
  parameter int DEPTH   = 8,
  parameter int TW_FRAC = fft_pkg::TW_FRAC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    state,
  input  logic [DW-1:0] w_r,
  input  logic [DW-1:0] w_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i
);

  import fft_pkg::*;

  logic signed [DW-1:0] dl_r [DEPTH];
  logic signed [DW-1:0] dl_i [DEPTH];

  logic signed [DW-1:0] a_r, a_i, b_r, b_i;
  logic signed [DW:0]   sum_r, sum_i, dif_r, dif_i;
  logic signed [DW-1:0] tw_r, tw_i;
  logic signed [DW-1:0] push_r, push_i;
  logic                 push;
  logic                 unused_msb;

  assign a_r = dl_r[DEPTH-1];
  assign a_i = dl_i[DEPTH-1];
  assign b_r = din_r;
  assign b_i = din_i;

  assign sum_r = {a_r[DW-1], a_r} + {b_r[DW-1], b_r};
  assign sum_i = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};
  assign dif_r = {a_r[DW-1], a_r} - {b_r[DW-1], b_r};
  assign dif_i = {a_i[DW-1], a_i} - {b_i[DW-1], b_i};

  assign unused_msb = ^{sum_r[DW], sum_i[DW],
                        dif_r[DW], dif_i[DW]};

  cmul_q #(
    .DW   (DW),
    .FRAC (TW_FRAC)
  ) u_cmul (
    .a_r (a_r),
    .a_i (a_i),
    .w_r (w_r),
    .w_i (w_i),
    .p_r (tw_r),
    .p_i (tw_i)
  );

  always_comb begin
    push   = 1'b0;
    push_r = b_r;
    push_i = b_i;
    unique case (state)
      ST_FILL: push = in_valid;
      ST_BFLY: begin
        push   = 1'b1;
        push_r = dif_r[DW-1:0];
        push_i = dif_i[DW-1:0];
      end
      ST_TWID: push = 1'b1;
      ST_IDLE: push = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        dl_r[i] <= '0;
        dl_i[i] <= '0;
      end
    end else if (push) begin
      dl_r[0] <= push_r;
      dl_i[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) begin
        dl_r[i] <= dl_r[i-1];
        dl_i[i] <= dl_i[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      unique case (state)
        ST_BFLY: begin
          out_valid <= 1'b1;
          dout_r    <= sum_r[DW-1:0];
          dout_i    <= sum_i[DW-1:0];
        end
        ST_TWID: begin
          out_valid <= 1'b1;
          dout_r    <= tw_r;
          dout_i    <= tw_i;
        end
        ST_FILL, ST_IDLE: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
